// File: rtl/leaf_pkg.sv
// leaf_pkg: shared widths, FSM state and packet layout for the leaf output arbiter.
package leaf_pkg;

    localparam int unsigned PAYLOAD_BITS          = 32;
    localparam int unsigned NUM_LEAF_BITS         = 5;
    localparam int unsigned NUM_PORT_BITS         = 4;
    localparam int unsigned NUM_ADDR_BITS         = 7;
    localparam int unsigned PACKET_BITS           = 1 + NUM_LEAF_BITS + NUM_PORT_BITS + NUM_ADDR_BITS + PAYLOAD_BITS;
    localparam int unsigned NUM_OUT_PORTS         = 3;
    localparam int unsigned CREDIT_BITS           = 8;
    localparam int unsigned CREDIT_SUM_BITS       = CREDIT_BITS + 1;
    localparam int unsigned FREESPACE_UPDATE_SIZE = 64;
    localparam int unsigned PKT_CNT_BITS          = 32;
    localparam int unsigned PTR_BITS              = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;

    // Field offsets inside the packet, LSB first
    localparam int unsigned PAYLOAD_LSB = 0;
    localparam int unsigned ADDR_LSB    = PAYLOAD_LSB + PAYLOAD_BITS;
    localparam int unsigned PORT_LSB    = ADDR_LSB + NUM_ADDR_BITS;
    localparam int unsigned LEAF_LSB    = PORT_LSB + NUM_PORT_BITS;
    localparam int unsigned VLD_BIT     = LEAF_LSB + NUM_LEAF_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    typedef struct packed {
        logic                     vld;
        logic [NUM_LEAF_BITS-1:0] leaf;
        logic [NUM_PORT_BITS-1:0] port;
        logic [NUM_ADDR_BITS-1:0] addr;
        logic [PAYLOAD_BITS-1:0]  payload;
    } packet_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at or above ptr_i with wrap.
module rr_arbiter #(
    parameter  int unsigned NUM_REQ  = 3,
    localparam int unsigned IDX_BITS = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0]  req_i,
    input  logic [IDX_BITS-1:0] ptr_i,
    output logic [NUM_REQ-1:0]  gnt_o,
    output logic [IDX_BITS-1:0] gnt_idx_o,
    output logic                gnt_vld_o
);

    always_comb begin
        int unsigned k;
        k         = 0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            k = 32'(ptr_i) + off;
            if (k >= NUM_REQ) k = k - NUM_REQ;
            if (!gnt_vld_o && req_i[IDX_BITS'(k)]) begin
                gnt_vld_o                 = 1'b1;
                gnt_idx_o                 = IDX_BITS'(k);
                gnt_o[IDX_BITS'(k)]       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/leaf_out_arbiter.sv
// leaf_out_arbiter: shares the leaf's BFT injection link among user output streams (credit-gated round robin).
// Define LEAF_OUT_ARB_PKT_CNT_EN to add per-port 32-bit grant counters on pkt_cnt.
module leaf_out_arbiter
    import leaf_pkg::*;
(
    input  logic                                    clk,
    input  logic                                    ap_rst_n,
    input  logic                                    en,
    input  logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0]   din_leaf_user2interface,
    input  logic [NUM_OUT_PORTS-1:0]                vld_user2interface,
    output logic [NUM_OUT_PORTS-1:0]                ack_interface2user,
    input  logic                                    cfg_wr_en,
    input  logic [NUM_PORT_BITS-1:0]                cfg_port,
    input  logic [NUM_LEAF_BITS-1:0]                cfg_dest_leaf,
    input  logic [NUM_PORT_BITS-1:0]                cfg_dest_port,
    input  logic                                    credit_upd_vld,
    input  logic [NUM_PORT_BITS-1:0]                credit_upd_port,
    output logic [PACKET_BITS-1:0]                  dout_leaf_interface2bft,
    input  logic                                    bft_ack
`ifdef LEAF_OUT_ARB_PKT_CNT_EN
    ,
    output logic [NUM_OUT_PORTS*PKT_CNT_BITS-1:0]   pkt_cnt
`endif
);

    logic [PAYLOAD_BITS-1:0]  payload_arr [NUM_OUT_PORTS];
    logic [NUM_OUT_PORTS-1:0] eligible;
    logic [NUM_OUT_PORTS-1:0] win_oh;
    logic [NUM_OUT_PORTS-1:0] gnt_hit;
    logic [PTR_BITS-1:0]      win_idx;
    logic                     win_vld;
    logic                     grant;

    state_e              state_q, state_d;
    logic [PTR_BITS-1:0] rr_ptr_q, rr_ptr_d;
    packet_t             pkt_q, pkt_d;

    logic [NUM_OUT_PORTS-1:0] cfg_valid_q;
    logic [NUM_LEAF_BITS-1:0] dest_leaf_q [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] dest_port_q [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit_q    [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit_d    [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] seq_q       [NUM_OUT_PORTS];

    for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_port
        assign payload_arr[i] = din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
        assign eligible[i]    = en & vld_user2interface[i] & cfg_valid_q[i] & (credit_q[i] != '0);
        assign gnt_hit[i]     = grant & win_oh[i];
    end

    rr_arbiter #(
        .NUM_REQ   (NUM_OUT_PORTS)
    ) u_rr_arbiter (
        .req_i     (eligible),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (win_oh),
        .gnt_idx_o (win_idx),
        .gnt_vld_o (win_vld)
    );

    // Grant when the output register is empty or being drained this cycle
    always_comb begin
        state_d  = state_q;
        pkt_d    = pkt_q;
        rr_ptr_d = rr_ptr_q;
        grant    = 1'b0;
        case (state_q)
            IDLE: grant = win_vld;
            SEND: begin
                if (bft_ack) begin
                    if (win_vld) begin
                        grant = 1'b1;
                    end else begin
                        pkt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (grant) begin
            state_d       = SEND;
            pkt_d.vld     = 1'b1;
            pkt_d.leaf    = dest_leaf_q[win_idx];
            pkt_d.port    = dest_port_q[win_idx];
            pkt_d.addr    = seq_q[win_idx];
            pkt_d.payload = payload_arr[win_idx];
            rr_ptr_d      = (win_idx == PTR_BITS'(NUM_OUT_PORTS - 1)) ? '0 : win_idx + PTR_BITS'(1);
        end
    end

    assign ack_interface2user      = (grant && ap_rst_n) ? win_oh : '0;
    assign dout_leaf_interface2bft = pkt_q;

    always_ff @(posedge clk) begin
        if (!ap_rst_n) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            pkt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            pkt_q    <= pkt_d;
        end
    end

    // Saturating credit: the carry bit flags overflow past the counter range
    always_comb begin
        logic [CREDIT_SUM_BITS-1:0] sum;
        sum = '0;
        for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
            sum = {1'b0, credit_q[i]};
            if (credit_upd_vld && (credit_upd_port == NUM_PORT_BITS'(i)))
                sum = sum + CREDIT_SUM_BITS'(FREESPACE_UPDATE_SIZE);
            if (gnt_hit[i])
                sum = sum - CREDIT_SUM_BITS'(1);
            credit_d[i] = sum[CREDIT_BITS] ? '1 : sum[CREDIT_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!ap_rst_n) begin
            cfg_valid_q <= '0;
            for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
                dest_leaf_q[i] <= '0;
                dest_port_q[i] <= '0;
                credit_q[i]    <= '0;
                seq_q[i]       <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) begin
                credit_q[i] <= credit_d[i];
                if (gnt_hit[i])
                    seq_q[i] <= seq_q[i] + NUM_ADDR_BITS'(1);
                if (cfg_wr_en && (cfg_port == NUM_PORT_BITS'(i))) begin
                    cfg_valid_q[i] <= 1'b1;
                    dest_leaf_q[i] <= cfg_dest_leaf;
                    dest_port_q[i] <= cfg_dest_port;
                end
            end
        end
    end

`ifdef LEAF_OUT_ARB_PKT_CNT_EN
    logic [PKT_CNT_BITS-1:0] pkt_cnt_q [NUM_OUT_PORTS];

    always_ff @(posedge clk) begin
        if (!ap_rst_n) begin
            for (int unsigned i = 0; i < NUM_OUT_PORTS; i++) pkt_cnt_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_OUT_PORTS; i++)
                if (gnt_hit[i]) pkt_cnt_q[i] <= pkt_cnt_q[i] + PKT_CNT_BITS'(1);
        end
    end

    for (genvar i = 0; i < NUM_OUT_PORTS; i++) begin : g_cnt
        assign pkt_cnt[i*PKT_CNT_BITS +: PKT_CNT_BITS] = pkt_cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// tb_leaf_out_arbiter: directed scenarios plus random traffic, checked against a behavioural model.
module tb_leaf_out_arbiter;
    import leaf_pkg::*;

    localparam int unsigned N = NUM_OUT_PORTS;

    logic           clk = 1'b0;
    logic           ap_rst_n, en, cfg_wr_en, credit_upd_vld, bft_ack;
    logic [N*32-1:0] din;
    logic [N-1:0]   vld, ack;
    logic [3:0]     cfg_port, cfg_dest_port, credit_upd_port;
    logic [4:0]     cfg_dest_leaf;
    logic [48:0]    dout;
`ifdef LEAF_OUT_ARB_PKT_CNT_EN
    logic [N*32-1:0] pkt_cnt;
`endif

    always #5 clk = ~clk;

    leaf_out_arbiter dut (
        .clk                     (clk),
        .ap_rst_n                (ap_rst_n),
        .en                      (en),
        .din_leaf_user2interface (din),
        .vld_user2interface      (vld),
        .ack_interface2user      (ack),
        .cfg_wr_en               (cfg_wr_en),
        .cfg_port                (cfg_port),
        .cfg_dest_leaf           (cfg_dest_leaf),
        .cfg_dest_port           (cfg_dest_port),
        .credit_upd_vld          (credit_upd_vld),
        .credit_upd_port         (credit_upd_port),
        .dout_leaf_interface2bft (dout),
        .bft_ack                 (bft_ack)
`ifdef LEAF_OUT_ARB_PKT_CNT_EN
        ,
        .pkt_cnt                 (pkt_cnt)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int last_win;

    // Reference model state
    bit          m_cfgv   [N];
    logic [4:0]  m_leaf   [N];
    logic [3:0]  m_dport  [N];
    int          m_credit [N];
    int          m_seq    [N];
    int unsigned m_cnt    [N];
    int          m_rr;
    logic [48:0] m_pkt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int p = 0; p < N; p++) begin
            m_cfgv[p] = 0; m_leaf[p] = '0; m_dport[p] = '0;
            m_credit[p] = 0; m_seq[p] = 0; m_cnt[p] = 0;
        end
        m_rr  = 0;
        m_pkt = '0;
    endfunction

    function automatic int model_winner();
        if (!ap_rst_n) return -1;
        if (m_pkt[48] && !bft_ack) return -1;
        for (int off = 0; off < N; off++) begin
            int p = (m_rr + off) % N;
            if (en && vld[p] && m_cfgv[p] && m_credit[p] > 0) return p;
        end
        return -1;
    endfunction

    function automatic void model_update(input int w);
        if (!ap_rst_n) begin
            model_reset();
            return;
        end
        for (int p = 0; p < N; p++) begin
            int c = m_credit[p];
            if (credit_upd_vld && credit_upd_port == p) c += 64;
            if (w == p) c -= 1;
            m_credit[p] = (c > 255) ? 255 : c;
        end
        if (w >= 0) begin
            m_pkt    = {1'b1, m_leaf[w], m_dport[w], 7'(m_seq[w]), din[w*32 +: 32]};
            m_seq[w] = (m_seq[w] + 1) % 128;
            m_rr     = (w + 1) % N;
            m_cnt[w] = m_cnt[w] + 1;
        end else if (m_pkt[48] && bft_ack) begin
            m_pkt = '0;
        end
        if (cfg_wr_en && cfg_port < N) begin
            m_cfgv[cfg_port]  = 1;
            m_leaf[cfg_port]  = cfg_dest_leaf;
            m_dport[cfg_port] = cfg_dest_port;
        end
    endfunction

    // One clock: check ack before the edge, advance the model, check dout after it
    task automatic tick();
        int w;
        logic [N-1:0] eack;
        @(negedge clk);
        w    = model_winner();
        eack = (w >= 0) ? N'(1 << w) : '0;
        check("ack", 64'(ack), 64'(eack));
        @(posedge clk);
        model_update(w);
        #1;
        check("dout", 64'(dout), 64'(m_pkt));
        last_win       = w;
        cfg_wr_en      = 1'b0;
        credit_upd_vld = 1'b0;
    endtask

    task automatic cfg(input int p, input logic [4:0] leaf, input logic [3:0] port);
        cfg_wr_en = 1'b1; cfg_port = 4'(p); cfg_dest_leaf = leaf; cfg_dest_port = port;
    endtask

    task automatic upd(input int p);
        credit_upd_vld = 1'b1; credit_upd_port = 4'(p);
    endtask

    initial begin
        logic [48:0] held;
        int          wins, exp_seq [6];
        bit          any_ack;

        ap_rst_n = 1'b0; en = 1'b1; cfg_wr_en = 1'b0; credit_upd_vld = 1'b0; bft_ack = 1'b1;
        din = '0; vld = '0; cfg_port = '0; cfg_dest_port = '0; cfg_dest_leaf = '0; credit_upd_port = '0;
        last_win = -1;
        model_reset();

        // Reset state
        tick(); tick();
        check("rst_dout", 64'(dout), 64'd0);
        check("rst_ack", 64'(ack), 64'd0);

        // Single packet framing
        ap_rst_n = 1'b1;
        cfg(0, 5'd3, 4'd2); tick();
        upd(0); tick();
        vld = 3'b001; din[31:0] = 32'hDEADBEEF; tick();
        check("t1_win", 64'(last_win), 64'd0);
        check("t1_pkt", 64'(dout), 64'({1'b1, 5'd3, 4'd2, 7'd0, 32'hDEADBEEF}));
        vld = '0; tick();
        check("t1_drain", 64'(dout), 64'd0);

        // Round robin across all ports
        cfg(1, 5'd1, 4'd5); upd(1); tick();
        cfg(2, 5'd7, 4'd9); upd(2); tick();
        vld = 3'b100; tick();
        check("t2_pre", 64'(last_win), 64'd2);
        vld = 3'b111;
        exp_seq = '{0, 1, 2, 0, 1, 2};
        for (int i = 0; i < 6; i++) begin
            din = {$urandom, $urandom, $urandom};
            tick();
            check("t2_rr", 64'(last_win), 64'(exp_seq[i]));
        end

        // Credit gating of port 1
        ap_rst_n = 1'b0; vld = '0; tick(); ap_rst_n = 1'b1;
        cfg(0, 5'd10, 4'd1); upd(0); tick();
        cfg(1, 5'd11, 4'd2); upd(2); tick();
        cfg(2, 5'd12, 4'd3); tick();
        vld = 3'b111;
        exp_seq = '{0, 2, 0, 2, 0, 1};
        for (int i = 0; i < 6; i++) begin
            if (i == 4) upd(1);
            din = {$urandom, $urandom, $urandom};
            tick();
            check("t3_gate", 64'(last_win), 64'(exp_seq[i]));
        end
        tick();
        check("t3_next", 64'(last_win), 64'd2);

        // Backpressure hold
        held = dout; any_ack = 1'b0; bft_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            din = {$urandom, $urandom, $urandom};
            tick();
            any_ack |= (last_win >= 0);
        end
        check("t4_hold", 64'(dout), 64'(held));
        check("t4_noack", 64'(any_ack), 64'd0);
        bft_ack = 1'b1; tick();
        check("t4_resume", 64'(last_win), 64'd0);

        // Sequence address wrap and credit exhaustion
        ap_rst_n = 1'b0; vld = '0; tick(); ap_rst_n = 1'b1;
        cfg(0, 5'd4, 4'd1); upd(0); tick();
        upd(0); tick();
        upd(0); tick();
        vld = 3'b001;
        for (int i = 0; i < 130; i++) begin
            din[31:0] = $urandom;
            tick();
            if (i == 127) check("t5_addr127", 64'(dout[38:32]), 64'd127);
            if (i == 128) check("t5_addr0", 64'(dout[38:32]), 64'd0);
        end
        wins = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (last_win == 0) wins++;
        end
        check("t5_credit", 64'(wins), 64'd62);

        // Reset while a packet is held
        upd(0); tick();
        tick();
        check("t6_held", 64'(dout[48]), 64'd1);
        bft_ack = 1'b0; ap_rst_n = 1'b0; tick();
        check("t6_rst_dout", 64'(dout), 64'd0);
        ap_rst_n = 1'b1; bft_ack = 1'b1; vld = 3'b111; wins = 0;
        for (int i = 0; i < 5; i++) begin
            if (i < 3) upd(i);
            tick();
            if (last_win >= 0) wins++;
        end
        check("t6_unconfigured", 64'(wins), 64'd0);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            ap_rst_n = ($urandom_range(0, 299) != 0);
            en       = ($urandom_range(0, 7) != 0);
            bft_ack  = ($urandom_range(0, 3) != 0);
            vld      = N'($urandom);
            din      = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 5) == 0) cfg($urandom_range(0, 4), 5'($urandom), 4'($urandom));
            if ($urandom_range(0, 3) == 0) upd($urandom_range(0, 4));
            tick();
        end

`ifdef LEAF_OUT_ARB_PKT_CNT_EN
        for (int p = 0; p < N; p++) check("pkt_cnt", 64'(pkt_cnt[p*32 +: 32]), 64'(m_cnt[p]));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
